// File: rtl/vespa_decode_stage.sv
// vespa_decode_stage: decode / operand-fetch stage of the VeSPA 32-bit pipeline.
// Decodes IR2, sign-extends its immediate, evaluates the branch condition,
// drives the register-file read addresses and loads the stage-3 registers
// (IR3, PC3, X3, Y3, MD3, cond_bit) with forwarding from Z5.
// Optional feature: define VESPA_COND_HOLD_EN to make cond_bit hold while pause3=1.
module vespa_decode_stage #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir2,
    input  logic [31:0] pc2,
    input  logic        c,
    input  logic        z,
    input  logic        n,
    input  logic        v,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    input  logic [31:0] z5,
    input  logic        nop3,
    input  logic        pause3,
    input  logic        c5a,
    input  logic        c6a,
    input  logic        c7,
    output logic [4:0]  a1,
    output logic [4:0]  a2,
    output logic [31:0] ir3,
    output logic [31:0] pc3,
    output logic [31:0] x3,
    output logic [31:0] y3,
    output logic [31:0] md3,
    output logic        cond2,
    output logic        cond_bit
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 5;
    localparam int unsigned CCW  = 4;

    // Opcodes that influence this stage; NOP (0), HLT (31) and unassigned codes
    // only pass through to IR3.
    localparam logic [OPW-1:0] OP_ADD = 5'd1;
    localparam logic [OPW-1:0] OP_SUB = 5'd2;
    localparam logic [OPW-1:0] OP_OR  = 5'd3;
    localparam logic [OPW-1:0] OP_AND = 5'd4;
    localparam logic [OPW-1:0] OP_NOT = 5'd5;
    localparam logic [OPW-1:0] OP_XOR = 5'd6;
    localparam logic [OPW-1:0] OP_CMP = 5'd7;
    localparam logic [OPW-1:0] OP_BR  = 5'd8;
    localparam logic [OPW-1:0] OP_JMP = 5'd9;
    localparam logic [OPW-1:0] OP_LD  = 5'd10;
    localparam logic [OPW-1:0] OP_LDI = 5'd11;
    localparam logic [OPW-1:0] OP_LDX = 5'd12;
    localparam logic [OPW-1:0] OP_ST  = 5'd13;
    localparam logic [OPW-1:0] OP_STX = 5'd14;

    logic [OPW-1:0]  opcode;
    logic [CCW-1:0]  cc;
    logic            is_alu;
    logic            is_br;
    logic            is_jmp;
    logic            is_ld;
    logic            is_ldi;
    logic            is_ldx;
    logic            is_st;
    logic            is_stx;
    logic            imm2;
    logic [XLEN-1:0] out2;
    logic            tmp_cond;

    logic [XLEN-1:0] ir3_d, ir3_q;
    logic [XLEN-1:0] pc3_d, pc3_q;
    logic [XLEN-1:0] x3_d,  x3_q;
    logic [XLEN-1:0] y3_d,  y3_q;
    logic [XLEN-1:0] md3_d, md3_q;
    logic            cond_bit_d, cond_bit_q;

    assign opcode = ir2[31:27];
    assign cc     = ir2[26:23];

    // Opcode decode into the class flags used by this stage
    always_comb begin
        is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR)  ||
                 (opcode == OP_AND) || (opcode == OP_NOT) || (opcode == OP_XOR) ||
                 (opcode == OP_CMP);
        is_br  = (opcode == OP_BR);
        is_jmp = (opcode == OP_JMP);
        is_ld  = (opcode == OP_LD);
        is_ldi = (opcode == OP_LDI);
        is_ldx = (opcode == OP_LDX);
        is_st  = (opcode == OP_ST);
        is_stx = (opcode == OP_STX);
    end

    // Immediate field selection and sign extension
    always_comb begin
        imm2 = 1'b0;
        out2 = '0;
        if ((is_alu || is_jmp) && ir2[16]) begin
            imm2 = 1'b1;
            out2 = {{16{ir2[15]}}, ir2[15:0]};
        end else if (is_ldi || is_ldx) begin
            imm2 = 1'b1;
            out2 = {{15{ir2[16]}}, ir2[16:0]};
        end else if (is_ld || is_st) begin
            imm2 = 1'b1;
            out2 = {{10{ir2[21]}}, ir2[21:0]};
        end else if (is_br) begin
            imm2 = 1'b1;
            out2 = {{9{ir2[22]}}, ir2[22:0]};
        end
    end

    // Register-file read addresses; stores read their data register on port 2
    always_comb begin
        a1 = ir2[21:17];
        a2 = (is_st || is_stx) ? ir2[26:22] : ir2[15:11];
    end

    // Branch condition evaluation from the flags
    always_comb begin
        tmp_cond = 1'b0;
        unique case (cc)
            4'd0:    tmp_cond = 1'b1;
            4'd2:    tmp_cond = ~c;
            4'd3:    tmp_cond = c;
            4'd4:    tmp_cond = ~v;
            4'd5:    tmp_cond = v;
            4'd6:    tmp_cond = z;
            4'd7:    tmp_cond = ~z;
            4'd8:    tmp_cond = (n == v);
            4'd9:    tmp_cond = (n != v);
            4'd10:   tmp_cond = ~z & (n == v);
            4'd11:   tmp_cond = z | (n != v);
            4'd12:   tmp_cond = ~n;
            4'd13:   tmp_cond = n;
            default: tmp_cond = 1'b0;
        endcase
        cond2 = is_br & tmp_cond;
    end

    // Next-state selection for the stage-3 registers; pause3 dominates every select
    always_comb begin
        ir3_d      = ir3_q;
        pc3_d      = pc3_q;
        x3_d       = x3_q;
        y3_d       = y3_q;
        md3_d      = md3_q;
        cond_bit_d = cond2;
        if (!pause3) begin
            ir3_d = nop3 ? NOP_WORD : ir2;
            pc3_d = pc2;

            if (c5a)        x3_d = z5;
            else if (is_br) x3_d = pc2;
            else            x3_d = r1;

            if (c6a)       y3_d = z5;
            else if (imm2) y3_d = out2;
            else           y3_d = r2;

            md3_d = c7 ? z5 : r2;
        end
`ifdef VESPA_COND_HOLD_EN
        if (pause3) cond_bit_d = cond_bit_q;
`endif
    end

    // Stage-3 pipeline registers with asynchronous clear
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ir3_q      <= NOP_WORD;
            pc3_q      <= RESET_PC;
            x3_q       <= '0;
            y3_q       <= '0;
            md3_q      <= '0;
            cond_bit_q <= 1'b0;
        end else begin
            ir3_q      <= ir3_d;
            pc3_q      <= pc3_d;
            x3_q       <= x3_d;
            y3_q       <= y3_d;
            md3_q      <= md3_d;
            cond_bit_q <= cond_bit_d;
        end
    end

    assign ir3      = ir3_q;
    assign pc3      = pc3_q;
    assign x3       = x3_q;
    assign y3       = y3_q;
    assign md3      = md3_q;
    assign cond_bit = cond_bit_q;

endmodule

// File: tb/tb_vespa_decode_stage.sv
// tb_vespa_decode_stage: scoreboard bench for vespa_decode_stage.
// Expected stage-3 state is computed by a reference model when stimulus is
// driven, queued, and compared after the following rising edge.
module tb_vespa_decode_stage;

    typedef struct {
        logic [31:0] ir2, pc2, r1, r2, z5;
        logic        c, z, n, v;
        logic        nop3, pause3, c5a, c6a, c7;
    } stim_t;

    typedef struct {
        logic [31:0] ir3, pc3, x3, y3, md3;
        logic        cond_bit;
    } exp_t;

    logic        clk, clr;
    logic [31:0] ir2, pc2, r1, r2, z5;
    logic        c, z, n, v;
    logic        nop3, pause3, c5a, c6a, c7;
    logic [4:0]  a1, a2;
    logic [31:0] ir3, pc3, x3, y3, md3;
    logic        cond2, cond_bit;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    exp_t model;

    vespa_decode_stage dut (
        .clk(clk), .clr(clr), .ir2(ir2), .pc2(pc2),
        .c(c), .z(z), .n(n), .v(v),
        .r1(r1), .r2(r2), .z5(z5),
        .nop3(nop3), .pause3(pause3), .c5a(c5a), .c6a(c6a), .c7(c7),
        .a1(a1), .a2(a2), .ir3(ir3), .pc3(pc3), .x3(x3), .y3(y3), .md3(md3),
        .cond2(cond2), .cond_bit(cond_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout n_pass=%0d n_checks=%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic exp_t reset_state();
        exp_t e;
        e.ir3 = 32'h0; e.pc3 = 32'h0; e.x3 = 32'h0; e.y3 = 32'h0; e.md3 = 32'h0;
        e.cond_bit = 1'b0;
        return e;
    endfunction

    function automatic logic ref_taken(input stim_t s);
        logic t;
        case (s.ir2[26:23])
            4'd0:  t = 1'b1;
            4'd2:  t = !s.c;
            4'd3:  t = s.c;
            4'd4:  t = !s.v;
            4'd5:  t = s.v;
            4'd6:  t = s.z;
            4'd7:  t = !s.z;
            4'd8:  t = (s.n ~^ s.v);
            4'd9:  t = (s.n ^ s.v);
            4'd10: t = !s.z && (s.n ~^ s.v);
            4'd11: t = s.z || (s.n ^ s.v);
            4'd12: t = !s.n;
            4'd13: t = s.n;
            default: t = 1'b0;
        endcase
        return (s.ir2[31:27] == 5'd8) && t;
    endfunction

    // Returns {has_imm, value}
    function automatic logic [32:0] ref_imm(input logic [31:0] ir);
        logic signed [31:0] val;
        logic               has;
        has = 1'b1;
        val = 0;
        case (ir[31:27])
            5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9: begin
                if (ir[16]) val = $signed(ir[15:0]);
                else has = 1'b0;
            end
            5'd11, 5'd12: val = $signed(ir[16:0]);
            5'd10, 5'd13: val = $signed(ir[21:0]);
            5'd8:         val = $signed(ir[22:0]);
            default:      has = 1'b0;
        endcase
        return {has, val};
    endfunction

    function automatic exp_t ref_step(input exp_t cur, input stim_t s);
        exp_t        e;
        logic [32:0] im;
        e  = cur;
        im = ref_imm(s.ir2);
        e.cond_bit = ref_taken(s);
`ifdef VESPA_COND_HOLD_EN
        if (s.pause3) e.cond_bit = cur.cond_bit;
`endif
        if (s.pause3) return e;
        e.ir3 = s.nop3 ? 32'h0 : s.ir2;
        e.pc3 = s.pc2;
        e.x3  = s.c5a ? s.z5 : ((s.ir2[31:27] == 5'd8) ? s.pc2 : s.r1);
        e.y3  = s.c6a ? s.z5 : (im[32] ? im[31:0] : s.r2);
        e.md3 = s.c7 ? s.z5 : s.r2;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.ir2 = 0; s.pc2 = 0; s.r1 = 0; s.r2 = 0; s.z5 = 0;
        s.c = 0; s.z = 0; s.n = 0; s.v = 0;
        s.nop3 = 0; s.pause3 = 0; s.c5a = 0; s.c6a = 0; s.c7 = 0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        ir2 = s.ir2; pc2 = s.pc2; r1 = s.r1; r2 = s.r2; z5 = s.z5;
        c = s.c; z = s.z; n = s.n; v = s.v;
        nop3 = s.nop3; pause3 = s.pause3; c5a = s.c5a; c6a = s.c6a; c7 = s.c7;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".ir3"}, ir3, e.ir3);
        check({tag, ".pc3"}, pc3, e.pc3);
        check({tag, ".x3"},  x3,  e.x3);
        check({tag, ".y3"},  y3,  e.y3);
        check({tag, ".md3"}, md3, e.md3);
        check({tag, ".cond_bit"}, 32'(cond_bit), 32'(e.cond_bit));
    endtask

    // One clock: drive on the falling edge, check decode, compare after the rising edge
    task automatic run_cycle(input string tag, input stim_t s);
        exp_t e;
        logic [4:0] exp_a2;
        @(negedge clk);
        apply(s);
        #1;
        exp_a2 = (s.ir2[31:27] == 5'd13 || s.ir2[31:27] == 5'd14) ? s.ir2[26:22] : s.ir2[15:11];
        check({tag, ".a1"}, 32'(a1), 32'(s.ir2[21:17]));
        check({tag, ".a2"}, 32'(a2), 32'(exp_a2));
        check({tag, ".cond2"}, 32'(cond2), 32'(ref_taken(s)));
        model = ref_step(model, s);
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_outputs(tag, e);
        end
    endtask

    initial begin
        stim_t s;
        apply(idle());
        clr   = 1'b1;
        model = reset_state();
        #12;
        check_outputs("reset", reset_state());
        @(negedge clk);
        clr = 1'b0;

        // ADD immediate form
        s = idle();
        s.ir2 = 32'h0843_8005; s.pc2 = 32'h40; s.r1 = 32'h10; s.r2 = 32'h77;
        run_cycle("add_imm", s);
        check("add_imm.x3_const", x3, 32'h10);
        check("add_imm.y3_const", y3, 32'hFFFF_8005);
        check("add_imm.ir3_const", ir3, 32'h0843_8005);

        // Branch BEQ taken then not taken
        s = idle();
        s.ir2 = {5'd8, 4'd6, 23'h7F_FFFC}; s.pc2 = 32'h100; s.z = 1'b1; s.r1 = 32'h5;
        run_cycle("beq_taken", s);
        check("beq_taken.x3_const", x3, 32'h100);
        check("beq_taken.y3_const", y3, 32'hFFFF_FFFC);
        check("beq_taken.cond_bit_const", 32'(cond_bit), 32'd1);
        s.z = 1'b0;
        run_cycle("beq_not", s);
        check("beq_not.cond_bit_const", 32'(cond_bit), 32'd0);

        // Store: a2 from the rst field, then MD3 forwarding
        s = idle();
        s.ir2 = {5'd13, 5'd7, 22'h00_0010}; s.pc2 = 32'h104; s.r2 = 32'hCAFE_0001;
        run_cycle("st", s);
        check("st.md3_const", md3, 32'hCAFE_0001);
        s.c7 = 1'b1; s.z5 = 32'hDEAD_BEEF;
        run_cycle("st_fwd", s);
        check("st_fwd.md3_const", md3, 32'hDEAD_BEEF);

        // Stall holds everything, combined nop3 loses to pause3, then bubble
        s = idle();
        s.ir2 = {5'd2, 5'd3, 5'd4, 1'b0, 5'd6, 11'd0}; s.pc2 = 32'h200;
        s.r1 = 32'h1111; s.r2 = 32'h2222;
        run_cycle("load", s);
        s.ir2 = 32'h1234_5678; s.pc2 = 32'h300; s.r1 = 32'h9999; s.r2 = 32'h8888;
        s.pause3 = 1'b1; s.nop3 = 1'b1; s.c5a = 1'b1; s.c6a = 1'b1; s.c7 = 1'b1; s.z5 = 32'h5555;
        run_cycle("stall", s);
        check("stall.pc3_const", pc3, 32'h200);
        check("stall.x3_const", x3, 32'h1111);
        s = idle();
        s.ir2 = 32'h0843_8005; s.nop3 = 1'b1;
        run_cycle("bubble", s);
        check("bubble.ir3_const", ir3, 32'h0);

        // Forwarding into X3 and Y3 for a register-form ADD
        s = idle();
        s.ir2 = {5'd1, 5'd2, 5'd3, 1'b0, 5'd4, 11'd0}; s.pc2 = 32'h400;
        s.r1 = 32'hAAAA; s.r2 = 32'hBBBB; s.c5a = 1'b1; s.c6a = 1'b1; s.z5 = 32'h1234_5678;
        run_cycle("fwd", s);
        check("fwd.x3_const", x3, 32'h1234_5678);
        check("fwd.y3_const", y3, 32'h1234_5678);

        // Asynchronous clear mid-stall, between clock edges
        s = idle();
        s.ir2 = 32'h0843_8005; s.pc2 = 32'h500; s.r1 = 32'h1; s.pause3 = 1'b1;
        run_cycle("pre_clr", s);
        #2;
        clr = 1'b1;
        #1;
        model = reset_state();
        check_outputs("async_clr", model);
        #1;
        clr = 1'b0;

        // Random traffic over all opcodes, flags and selects
        for (int i = 0; i < 400; i++) begin
            s.ir2    = $urandom();
            s.pc2    = $urandom();
            s.r1     = $urandom();
            s.r2     = $urandom();
            s.z5     = $urandom();
            {s.c, s.z, s.n, s.v} = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) s.ir2[31:27] = 5'd8;
            s.pause3 = ($urandom_range(0, 4) == 0);
            s.nop3   = ($urandom_range(0, 4) == 0);
            s.c5a    = ($urandom_range(0, 3) == 0);
            s.c6a    = ($urandom_range(0, 3) == 0);
            s.c7     = ($urandom_range(0, 3) == 0);
            run_cycle("rand", s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
